// File: rtl/seq_shifter_if.sv
// ---------------------------------------------------------------------------
// seq_shifter_if
//   Operand/result handshake bundle for the bit-serial shifter.
//
//   Request channel  (producer -> unit): in_valid, op, a, b
//                    (unit -> producer): in_ready
//   Result channel   (unit -> consumer): out_valid, y
//                    (consumer -> unit): out_ready
//
//   Modports:
//     master - producer/consumer side (drives requests, accepts results)
//     slave  - shifter side (accepts requests, drives results)
// ---------------------------------------------------------------------------
interface seq_shifter_if #(
    parameter int WIDTH = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, y
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, y
    );
endinterface

// File: rtl/seq_shifter.sv
// ---------------------------------------------------------------------------
// seq_shifter
//   Multi-cycle bit-serial shift unit: moves the operand one bit position per
//   clock. Low-area counterpart to a single-cycle barrel shifter.
//   Ops (bus.op): 00 SLL, 01 SRL, 10 SRA, 11 ROL.
//
//   Ports:
//     clk  - single clock, all state updates on posedge
//     rst  - synchronous, active-high reset
//     bus  - seq_shifter_if.slave: in_valid/in_ready/op/a/b request channel,
//            out_valid/out_ready/y result channel
//
//   Timing: an operand accepted in cycle T produces out_valid in cycle T+1+N,
//   where N is the number of single-bit steps (0..WIDTH).
//   WIDTH must be a power of two and at least 2.
// ---------------------------------------------------------------------------
module seq_shifter #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    seq_shifter_if.slave bus
);

    localparam int LW = $clog2(WIDTH);  // bits needed for b mod WIDTH
    localparam int CW = LW + 1;         // count must also hold WIDTH itself

    localparam logic [CW-1:0]  CNT_FULL  = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]  CNT_ZERO  = '0;
    localparam logic [WIDTH:0] WIDTH_EXT = (WIDTH + 1)'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROL = 2'b11
    } op_e;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             in_ready;
    logic             out_valid;
    logic             b_sat;
    logic [CW-1:0]    accept_cnt;
    logic [WIDTH-1:0] step_data;

    // One single-bit step of the selected operation.
    function automatic logic [WIDTH-1:0] shift_step(input op_e op, input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        r = d;
        case (op)
            OP_SLL:  r = {d[WIDTH-2:0], 1'b0};
            OP_SRL:  r = {1'b0, d[WIDTH-1:1]};
            OP_SRA:  r = {d[WIDTH-1], d[WIDTH-1:1]};
            OP_ROL:  r = {d[WIDTH-2:0], d[WIDTH-1]};
            default: r = d;
        endcase
        return r;
    endfunction

    // Step count for the operand being offered. Shifts saturate at WIDTH
    // steps (further steps would not change the result); rotates wrap, so
    // only b mod WIDTH matters, which is just the low LW bits of b.
    always_comb begin
        b_sat = ({1'b0, bus.b} >= WIDTH_EXT);
        if (op_e'(bus.op) == OP_ROL) begin
            accept_cnt = {1'b0, bus.b[LW-1:0]};
        end else if (b_sat) begin
            accept_cnt = CNT_FULL;
        end else begin
            accept_cnt = {1'b0, bus.b[LW-1:0]};
        end
    end

    assign step_data = shift_step(op_q, data_q);

    // Next-state and output decode.
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        y_d       = y_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    data_d = bus.a;
                    op_d   = op_e'(bus.op);
                    cnt_d  = accept_cnt;
                    if (accept_cnt == CNT_ZERO) begin
                        // Zero-step op: result is the operand itself.
                        state_d = S_DONE;
                        y_d     = bus.a;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end

            S_SHIFT: begin
                data_d = step_data;
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    // y is captured only on entry to DONE so it stays
                    // stable through SHIFT and while the consumer stalls.
                    state_d = S_DONE;
                    y_d     = step_data;
                end
            end

            S_DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.y         = y_q;

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // NOTE: data and y are reset along with the control state because y is
    // visible on the port and must read 0 after reset; there is no memory
    // array here, so this costs only a handful of flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_SLL;
            data_q  <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
        end
    end

endmodule

// File: tb/tb_seq_shifter.sv
// ---------------------------------------------------------------------------
// tb_seq_shifter
//   Self-checking bench for seq_shifter (WIDTH=4): directed cases for
//   saturation, zero shifts, backpressure and reset abort, followed by random
//   back-to-back operations compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_seq_shifter;

    localparam int W = 4;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    seq_shifter_if #(.WIDTH(W)) bus ();

    seq_shifter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference result from the operation's arithmetic meaning.
    function automatic logic [W-1:0] model_y(input logic [1:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        int ai, bi, s, r, k;
        ai = int'(a);
        bi = int'(b);
        case (op)
            2'b00: r = (bi >= W) ? 0 : (ai << bi);
            2'b01: r = (bi >= W) ? 0 : (ai >> bi);
            2'b10: begin
                s = a[W-1] ? (ai - (1 << W)) : ai;
                r = s >>> bi;
            end
            default: begin
                k = bi % W;
                r = (ai << k) | (ai >> (W - k));
            end
        endcase
        return r[W-1:0];
    endfunction

    // Reference latency: accept cycle to first out_valid cycle.
    function automatic int model_lat(input logic [1:0] op, input logic [W-1:0] b);
        int bi;
        bi = int'(b);
        if (op == 2'b11) return 1 + (bi % W);
        return 1 + ((bi < W) ? bi : W);
    endfunction

    // Issue one operation, measure latency, optionally stall the result for
    // `stall` cycles (with a competing request held on the input side), then
    // complete the handshake.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int stall);
        logic [W-1:0] exp_y;
        int           exp_lat;
        int           lat;
        exp_y   = model_y(op, a, b);
        exp_lat = model_lat(op, b);

        check({tag, "/in_ready_idle"}, 32'(bus.in_ready), 32'd1);
        bus.op        = op;
        bus.a         = a;
        bus.b         = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = (stall == 0);
        tick();
        // Scramble operands: the unit must have latched them.
        bus.in_valid = 1'b0;
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        bus.op       = 2'($urandom);

        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "/y"}, 32'(bus.y), 32'(exp_y));

        for (int i = 0; i < stall; i++) begin
            bus.in_valid = 1'b1;
            check({tag, "/stall_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, "/stall_y"}, 32'(bus.y), 32'(exp_y));
            check({tag, "/stall_in_ready"}, 32'(bus.in_ready), 32'd0);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check({tag, "/valid_drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, "/y_hold"}, 32'(bus.y), 32'(exp_y));
    endtask

    initial begin
        logic [1:0]   r_op;
        logic [W-1:0] r_a;
        logic [W-1:0] r_b;
        int           r_stall;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = 2'b00;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check("reset/in_ready", 32'(bus.in_ready), 32'd1);
        check("reset/out_valid", 32'(bus.out_valid), 32'd0);
        check("reset/y", 32'(bus.y), 32'd0);
        rst = 1'b0;
        tick();

        // Basic shifts and saturation.
        run_op("sll_0011_b2", 2'b00, 4'b0011, 4'd2, 0);
        run_op("sra_1000_b1", 2'b10, 4'b1000, 4'd1, 0);
        run_op("sra_1010_b9", 2'b10, 4'b1010, 4'd9, 0);

        // Zero shift, saturated logical shift, rotate wrap.
        run_op("srl_1011_b0", 2'b01, 4'b1011, 4'd0, 0);
        run_op("srl_1111_b15", 2'b01, 4'b1111, 4'd15, 0);
        run_op("rol_1001_b5", 2'b11, 4'b1001, 4'd5, 0);
        run_op("sll_0111_b4", 2'b00, 4'b0111, 4'd4, 0);
        run_op("sra_0110_b12", 2'b10, 4'b0110, 4'd12, 0);

        // Backpressure: result held for 6 cycles.
        run_op("bp_sll_0001_b1", 2'b00, 4'b0001, 4'd1, 6);
        check("bp/in_ready_after", 32'(bus.in_ready), 32'd1);

        // Reset during SHIFT aborts the op (previous y is nonzero).
        bus.op       = 2'b01;
        bus.a        = 4'b1100;
        bus.b        = 4'd3;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid/in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_mid/out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_mid/y", 32'(bus.y), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_mid/no_result", 32'(bus.out_valid), 32'd0);
        end
        run_op("after_rst_srl_1100_b3", 2'b01, 4'b1100, 4'd3, 0);

        // Random back-to-back traffic with occasional short stalls.
        for (int n = 0; n < 60; n++) begin
            r_op    = 2'($urandom_range(0, 3));
            r_a     = W'($urandom_range(0, 15));
            r_b     = W'($urandom_range(0, 15));
            r_stall = int'($urandom_range(0, 2));
            run_op($sformatf("rand%0d_op%0d_a%0h_b%0h", n, r_op, r_a, r_b), r_op, r_a, r_b, r_stall);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
